int_redirect_ctrl: RTL and testbench
====================================

# int_redirect_ctrl

Fetch-control sequencer that drives the Fetch stage's redirect inputs (`stall`, `jumpBit`, `branchIR`, `interruptBit`) from branch resolution, hazard detection and the external interrupt line. It owns interrupt entry:

- waits for the current instruction to finish (including a two-word immediate);
- pushes the 32-bit return PC to the stack path as two 16-bit words;
- steers Fetch to the interrupt vector at address 0;
- tracks the in-service state until return.

It sits between Execute/Memory (branch and `rti` sources) and Fetch.

## Interface
- No parameters; widths are fixed by the 32-bit PC and 16-bit instruction word.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `int_req` in 1: external interrupt request, level-sensitive.
- `branch_taken` in 1: resolved taken branch, jump or `rti` redirect this cycle.
- `branch_target` in 32: target PC accompanying `branch_taken`.
- `hazard_stall` in 1: stall request from the hazard unit.
- `is_two_word` in 1: the word Fetch is currently returning is the first half of an instruction with an immediate.
- `next_pc` in 32: Fetch's `nextPc` (address of the next word).
- `rti` in 1: one-cycle pulse, return-from-interrupt retiring.
- `push_ack` in 1: stack write accepted this cycle.
- `stall` out 1: to Fetch `stall`.
- `jump_bit` out 1: to Fetch `jumpBit`.
- `branch_ir` out 32: to Fetch `branchIR`.
- `interrupt_bit` out 1: to Fetch `interruptBit`.
- `flush_if_id` out 1: clear the IF/ID register.
- `push_req` out 1: stack write request.
- `push_data` out 16: stack write data.
- `int_active` out 1: interrupt in service.

## Operation
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, ACTIVE. Registers: `state`, `ret_addr[31:0]`.
- Redirect outputs are combinational from `state` and the inputs. `state` and `ret_addr` are registered.
- **IDLE / ACTIVE:**
  - `jump_bit = branch_taken`
  - `branch_ir = branch_target`
  - `flush_if_id = branch_taken`
  - `stall = hazard_stall`
- **IDLE, interrupt acceptance:** `int_req` is accepted only when `branch_taken = 0` and `hazard_stall = 0`. Otherwise acceptance is deferred; `int_req` is re-sampled every cycle.
  - On acceptance with `is_two_word = 0`: `ret_addr <= next_pc`, go to PUSH_HI.
  - On acceptance with `is_two_word = 1`: go to DRAIN.
- **DRAIN** (one cycle): outputs as in IDLE.
  - `ret_addr <= branch_taken ? branch_target : next_pc`.
  - Go to PUSH_HI.
- **PUSH_HI:**
  - `stall = 1`, `push_req = 1`, `push_data = ret_addr[31:16]`, `jump_bit = 0`.
  - If `branch_taken`: `ret_addr <= branch_target`, stay.
  - Else if `push_ack`: go to PUSH_LO.
  - Else hold.
- **PUSH_LO:**
  - `stall = 1`, `push_req = 1`, `push_data = ret_addr[15:0]`.
  - If `branch_taken`: `ret_addr <= branch_target`, go to PUSH_HI (restart the push pair). This takes priority over `push_ack`.
  - Else if `push_ack`: go to VECTOR.
- **VECTOR** (one cycle):
  - `interrupt_bit = 1`, `flush_if_id = 1`, `stall = 0`, `jump_bit = 0`.
  - Go to ACTIVE.
- **ACTIVE:**
  - `int_active = 1`.
  - `int_req` is ignored (no nesting).
  - `rti` moves to IDLE on the next edge. The return-PC redirect arrives on `branch_taken`/`branch_target` the same cycle and passes through.
- All outputs not listed for a state are 0. `branch_ir` always equals `branch_target`.
- `int_active` is 1 in states VECTOR and ACTIVE.

## Timing
- **Reset** (`rst` high at an edge): state = IDLE, `ret_addr = 0`. All outputs are 0 while in IDLE with inputs low. Reset in any state aborts interrupt entry and drops `push_req` the next cycle; a half-written stack pair is not repaired.
- **Branch redirect:** 0-cycle latency. `jump_bit` follows `branch_taken` combinationally in IDLE, DRAIN and ACTIVE.
- **Interrupt latency:** from `int_req` sampled (with no two-word instruction, no branch, no stall) to `interrupt_bit` is 3 cycles plus any `push_ack` wait cycles. It is 4 cycles when DRAIN is taken.
- **Stack handshake:** `push_data` is stable while `push_req` is high and `push_ack` is low. Exactly two accepted pushes per interrupt (hi, then lo), barring reset.
- **Simultaneous events:**
  - `branch_taken` + `int_req` in IDLE: the branch is taken and the interrupt is deferred one cycle.
  - `rti` + `int_req` in ACTIVE: go to IDLE; the interrupt is accepted no earlier than the next cycle.
- `hazard_stall` is ignored in PUSH_HI, PUSH_LO and VECTOR, because the block already drives stall high in both push states and VECTOR must not stall.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs, then release with inputs low. Required: all outputs 0, `int_active = 0`.
- **Plain interrupt:** `next_pc = 0x0000_0025`, `int_req = 1`, `push_ack` tied high. Required sequence:
  - `push_data` is `0x0000`, then `0x0025`, with `stall = 1` for those 2 cycles;
  - then `interrupt_bit = 1` and `flush_if_id = 1` for 1 cycle;
  - then `int_active` stays 1.
- **Two-word drain:** `int_req` with `is_two_word = 1`. Required: one DRAIN cycle with `stall = 0`; `ret_addr` captures `next_pc = 0x31` from that cycle; pushes `0x0000`, `0x0031`.
- **Push backpressure:** `push_ack` low 3 cycles in PUSH_HI. Required: `push_data = 0x0000` and `stall = 1` held; `interrupt_bit` is delayed exactly 3 cycles.
- **Branch during push:** in PUSH_LO, `branch_taken = 1` with target `0x0000_0050`. Required: restart, pushes `0x0000` then `0x0050`; `jump_bit` stays 0.
- **Return:** in ACTIVE, `rti` + `branch_taken` with target `0x25`. Required: `jump_bit = 1`, `branch_ir = 0x25`; IDLE next cycle; a new `int_req` is accepted after that.

Source files
------------

// File: rtl/int_redirect_ctrl.sv
// Fetch redirect sequencer: passes branch/hazard redirects through to Fetch and
// runs interrupt entry (drain, push the 32-bit return PC as two words, vector to 0).
module int_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        hazard_stall,
  input  logic        is_two_word,
  input  logic [31:0] next_pc,
  input  logic        rti,
  input  logic        push_ack,
  output logic        stall,
  output logic        jump_bit,
  output logic [31:0] branch_ir,
  output logic        interrupt_bit,
  output logic        flush_if_id,
  output logic        push_req,
  output logic [15:0] push_data,
  output logic        int_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PUSH_HI = 3'd2,
    ST_PUSH_LO = 3'd3,
    ST_VECTOR  = 3'd4,
    ST_ACTIVE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ret_addr_q, ret_addr_d;

  // Next-state and return-address capture.
  always_comb begin
    state_d    = state_q;
    ret_addr_d = ret_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (int_req && !branch_taken && !hazard_stall) begin
          if (is_two_word) begin
            state_d = ST_DRAIN;
          end else begin
            ret_addr_d = next_pc;
            state_d    = ST_PUSH_HI;
          end
        end
      end
      ST_DRAIN: begin
        ret_addr_d = branch_taken ? branch_target : next_pc;
        state_d    = ST_PUSH_HI;
      end
      ST_PUSH_HI: begin
        if (branch_taken) begin
          ret_addr_d = branch_target;
        end else if (push_ack) begin
          state_d = ST_PUSH_LO;
        end
      end
      // A late redirect invalidates the half-pushed PC, so restart the pair.
      ST_PUSH_LO: begin
        if (branch_taken) begin
          ret_addr_d = branch_target;
          state_d    = ST_PUSH_HI;
        end else if (push_ack) begin
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (rti) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ret_addr_d = 32'h0000_0000;
      end
    endcase
  end

  // Fetch-facing outputs; redirects stay combinational for zero-cycle branch latency.
  always_comb begin
    stall         = 1'b0;
    jump_bit      = 1'b0;
    branch_ir     = branch_target;
    interrupt_bit = 1'b0;
    flush_if_id   = 1'b0;
    push_req      = 1'b0;
    push_data     = 16'h0000;
    int_active    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        jump_bit    = branch_taken;
        flush_if_id = branch_taken;
        stall       = hazard_stall;
      end
      ST_ACTIVE: begin
        jump_bit    = branch_taken;
        flush_if_id = branch_taken;
        stall       = hazard_stall;
        int_active  = 1'b1;
      end
      ST_PUSH_HI: begin
        stall     = 1'b1;
        push_req  = 1'b1;
        push_data = ret_addr_q[31:16];
      end
      ST_PUSH_LO: begin
        stall     = 1'b1;
        push_req  = 1'b1;
        push_data = ret_addr_q[15:0];
      end
      ST_VECTOR: begin
        interrupt_bit = 1'b1;
        flush_if_id   = 1'b1;
        int_active    = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      ret_addr_q <= ret_addr_d;
    end
  end

endmodule

// File: tb/tb_int_redirect_ctrl.sv
// Scoreboard bench for int_redirect_ctrl: stimulus queues per-cycle expected outputs
// and expected stack words; a negedge monitor pops and compares them.
module tb_int_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        hazard_stall;
  logic        is_two_word;
  logic [31:0] next_pc;
  logic        rti;
  logic        push_ack;
  logic        stall;
  logic        jump_bit;
  logic [31:0] branch_ir;
  logic        interrupt_bit;
  logic        flush_if_id;
  logic        push_req;
  logic [15:0] push_data;
  logic        int_active;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  typedef struct {
    string       nm;
    logic [53:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] push_q[$];
  exp_t        mon_e;
  logic [53:0] got_vec;
  logic [15:0] exp_word;

  int_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .int_req       (int_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .is_two_word   (is_two_word),
    .next_pc       (next_pc),
    .rti           (rti),
    .push_ack      (push_ack),
    .stall         (stall),
    .jump_bit      (jump_bit),
    .branch_ir     (branch_ir),
    .interrupt_bit (interrupt_bit),
    .flush_if_id   (flush_if_id),
    .push_req      (push_req),
    .push_data     (push_data),
    .int_active    (int_active)
  );

  always #5 clk = ~clk;

  // Monitor: compare every cycle's outputs and every accepted stack word.
  always @(negedge clk) begin
    if (mon_en) begin
      got_vec = {stall, jump_bit, interrupt_bit, flush_if_id, push_req, int_active,
                 push_data, branch_ir};
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (got_vec !== mon_e.vec) begin
          failures++;
          $display("FAIL %s: got stall/jump/intb/flush/preq/act=%b data=%h bir=%h, expected %b data=%h bir=%h",
                   mon_e.nm, got_vec[53:48], got_vec[47:32], got_vec[31:0],
                   mon_e.vec[53:48], mon_e.vec[47:32], mon_e.vec[31:0]);
        end
      end
      if (push_req === 1'b1 && push_ack === 1'b1) begin
        checks++;
        if (push_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_push: got word %h, expected no push", push_data);
        end else begin
          exp_word = push_q.pop_front();
          if (push_data !== exp_word) begin
            failures++;
            $display("FAIL push_word: got %h, expected %h", push_data, exp_word);
          end
        end
      end
    end
  end

  task automatic clr_in();
    int_req       = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    hazard_stall  = 1'b0;
    is_two_word   = 1'b0;
    next_pc       = 32'h0000_0000;
    rti           = 1'b0;
    push_ack      = 1'b0;
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic s, input logic j, input logic ib,
                     input logic fl, input logic pr, input logic [15:0] pd,
                     input logic act);
    exp_t e;
    e.nm  = nm;
    e.vec = {s, j, ib, fl, pr, act, pd, branch_target};
    exp_q.push_back(e);
    if (pr && push_ack) push_q.push_back(pd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int_req       = 1'($urandom_range(1));
      branch_taken  = 1'($urandom_range(1));
      branch_target = $urandom;
      hazard_stall  = 1'($urandom_range(1));
      is_two_word   = 1'($urandom_range(1));
      next_pc       = $urandom;
      rti           = 1'($urandom_range(1));
      push_ack      = 1'($urandom_range(1));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clr_in();
    mon_en = 1'b1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Plain interrupt, ack tied high.
    next_pc = 32'h0000_0025; int_req = 1'b1; push_ack = 1'b1;
    cyc("p_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    int_req = 1'b0;
    cyc("p_hi",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    cyc("p_lo",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0025, 1'b0);
    cyc("p_vec",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    cyc("p_act",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Return with a simultaneous new request that must not be taken yet.
    rti = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0025; int_req = 1'b1;
    cyc("ret",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Two-word drain plus three cycles of push backpressure.
    rti = 1'b0; branch_taken = 1'b0; branch_target = 32'h0000_0000;
    is_two_word = 1'b1; next_pc = 32'h0000_0031;
    cyc("d_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    int_req = 1'b0; is_two_word = 1'b0;
    cyc("d_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    push_ack = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("bp_hi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    push_ack = 1'b1;
    cyc("d_hi",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    cyc("d_lo",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0031, 1'b0);
    cyc("d_vec",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    int_req = 1'b1; hazard_stall = 1'b1;
    cyc("act_ign", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    int_req = 1'b0; hazard_stall = 1'b0;
    rti = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    cyc("ret2",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Deferral by branch, then by hazard stall.
    rti = 1'b0; branch_target = 32'h0000_0060; int_req = 1'b1; next_pc = 32'h0000_0061;
    cyc("br_defer", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    branch_taken = 1'b0; branch_target = 32'h0000_0000; hazard_stall = 1'b1;
    cyc("hz_defer", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Branches during both push states.
    hazard_stall = 1'b0; next_pc = 32'h0001_0025;
    cyc("b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    int_req = 1'b0; push_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0002_0000;
    cyc("b_hi_br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    branch_taken = 1'b0; branch_target = 32'h0000_0000; push_ack = 1'b1;
    cyc("b_hi",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h0000_0050; push_ack = 1'b0;
    cyc("b_lo_br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    branch_taken = 1'b0; branch_target = 32'h0000_0000; push_ack = 1'b1;
    cyc("b_hi2",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    cyc("b_lo2",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0050, 1'b0);
    cyc("b_vec",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    rti = 1'b1;
    cyc("ret3",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset in the middle of interrupt entry.
    rti = 1'b0; int_req = 1'b1; next_pc = 32'h0000_0077;
    cyc("r_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    int_req = 1'b0; push_ack = 1'b0; rst = 1'b1;
    cyc("rst_hi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    rst = 1'b0;
    cyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || push_q.size() != 0) begin
      failures++;
      $display("FAIL drained: got %0d cycle and %0d push entries left, expected 0 and 0",
               exp_q.size(), push_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
